// File: rtl/gpu2d_pkg.sv
// Shared types and constants for the 2D sprite pipeline.
package gpu2d_pkg;

    // Number of live sprite table entries; the renderer halts its fetch here too.
    localparam int SPRITE_TABLE_DEPTH = 100;
    localparam int SPRITE_ADDR_W      = 10;
    localparam int SPRITE_DATA_W      = 8;

    typedef enum logic [1:0] {
        ACTIVE     = 2'd0,
        DRAIN      = 2'd1,
        BLANK_IDLE = 2'd2
    } e_sched_state;

    typedef enum logic {
        RR_HOST = 1'b0,
        RR_ANIM = 1'b1
    } e_rr_sel;

    typedef struct packed {
        logic [SPRITE_ADDR_W-1:0] addr;
        logic [SPRITE_DATA_W-1:0] data;
    } sprite_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push and pop may coincide.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Flag generation and pointer/count next-state; full uses the pre-pop count.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sprite_table_scheduler.sv
// Queues sprite table writes from host and animation engine and commits
// them to the coordinate BRAM only while vblank is high.
module sprite_table_scheduler
    import gpu2d_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int TABLE_DEPTH = SPRITE_TABLE_DEPTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WIDTH   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vblank,
    input  logic                  host_valid,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_ready,
    input  logic                  anim_valid,
    input  logic [ADDR_WIDTH-1:0] anim_addr,
    input  logic [DATA_WIDTH-1:0] anim_data,
    output logic                  anim_ready,
    output logic                  cbram_we,
    output logic [ADDR_WIDTH-1:0] cbram_waddr,
    output logic [DATA_WIDTH-1:0] cbram_d,
    output logic [CNT_WIDTH-1:0]  pending,
    output logic                  commit_done,
    output logic                  addr_err
);
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int LIM_W   = ADDR_WIDTH + 1;
    // One extra bit so a table depth equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [LIM_W-1:0] TABLE_LIM = LIM_W'(TABLE_DEPTH);

    e_sched_state          state_q, state_d;
    e_rr_sel               rr_q, rr_d;
    logic                  cbram_we_q, cbram_we_d;
    logic [ADDR_WIDTH-1:0] cbram_waddr_q, cbram_waddr_d;
    logic [DATA_WIDTH-1:0] cbram_d_q, cbram_d_d;
    logic                  commit_done_q, commit_done_d;
    logic                  addr_err_q, addr_err_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    fifo_din, fifo_dout;
    logic [CNT_WIDTH-1:0]  fifo_count;

    logic                  host_acc, anim_acc, req_accept, req_legal;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Round-robin grant; with no requester valid the pointer owner holds ready so both never assert.
    always_comb begin
        host_ready = 1'b0;
        anim_ready = 1'b0;
        if (!fifo_full) begin
            if (host_valid && anim_valid) begin
                host_ready = (rr_q == RR_HOST);
                anim_ready = (rr_q == RR_ANIM);
            end else if (host_valid) begin
                host_ready = 1'b1;
            end else if (anim_valid) begin
                anim_ready = 1'b1;
            end else begin
                host_ready = (rr_q == RR_HOST);
                anim_ready = (rr_q == RR_ANIM);
            end
        end
    end

    // Accepted-transfer handling: legal addresses are queued, illegal ones only flag an error.
    always_comb begin
        host_acc   = host_valid && host_ready;
        anim_acc   = anim_valid && anim_ready;
        req_accept = host_acc || anim_acc;
        req_addr   = host_acc ? host_addr : anim_addr;
        req_data   = host_acc ? host_data : anim_data;
        req_legal  = ({1'b0, req_addr} < TABLE_LIM);
        fifo_push  = req_accept && req_legal;
        fifo_din   = {req_addr, req_data};
        addr_err_d = req_accept && !req_legal;
        rr_d       = rr_q;
        if (host_acc) begin
            rr_d = RR_ANIM;
        end else if (anim_acc) begin
            rr_d = RR_HOST;
        end
    end

    // Commit sequencing: pops only while vblank is high; commit_done fires once per drain-to-empty.
    always_comb begin
        state_d       = state_q;
        fifo_pop      = 1'b0;
        commit_done_d = 1'b0;
        case (state_q)
            ACTIVE, DRAIN: begin
                if (!vblank) begin
                    state_d = ACTIVE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    commit_done_d = 1'b1;
                    state_d       = BLANK_IDLE;
                end
            end
            BLANK_IDLE: begin
                if (!vblank) begin
                    state_d = ACTIVE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = DRAIN;
                end
            end
            default: state_d = ACTIVE;
        endcase
        cbram_we_d    = fifo_pop;
        cbram_waddr_d = fifo_pop ? fifo_dout[ENTRY_W-1:DATA_WIDTH] : '0;
        cbram_d_d     = fifo_pop ? fifo_dout[DATA_WIDTH-1:0] : '0;
    end

    // State, arbitration pointer and registered BRAM/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACTIVE;
            rr_q          <= RR_HOST;
            cbram_we_q    <= 1'b0;
            cbram_waddr_q <= '0;
            cbram_d_q     <= '0;
            commit_done_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cbram_we_q    <= cbram_we_d;
            cbram_waddr_q <= cbram_waddr_d;
            cbram_d_q     <= cbram_d_d;
            commit_done_q <= commit_done_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign cbram_we    = cbram_we_q;
    assign cbram_waddr = cbram_waddr_q;
    assign cbram_d     = cbram_d_q;
    assign commit_done = commit_done_q;
    assign addr_err    = addr_err_q;
    assign pending     = fifo_count;

endmodule

// File: tb/tb_sprite_table_scheduler.sv
// Bench for sprite_table_scheduler: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_sprite_table_scheduler;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vblank = 1'b0;
    logic          host_valid = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_data = '0;
    logic          host_ready;
    logic          anim_valid = 1'b0;
    logic [AW-1:0] anim_addr = '0;
    logic [DW-1:0] anim_data = '0;
    logic          anim_ready;
    logic          cbram_we;
    logic [AW-1:0] cbram_waddr;
    logic [DW-1:0] cbram_d;
    logic [CW-1:0] pending;
    logic          commit_done;
    logic          addr_err;

    always #5 clk = ~clk;

    sprite_table_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vblank      (vblank),
        .host_valid  (host_valid),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .anim_valid  (anim_valid),
        .anim_addr   (anim_addr),
        .anim_data   (anim_data),
        .anim_ready  (anim_ready),
        .cbram_we    (cbram_we),
        .cbram_waddr (cbram_waddr),
        .cbram_d     (cbram_d),
        .pending     (pending),
        .commit_done (commit_done),
        .addr_err    (addr_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending writes as a queue, plus what the BRAM side should show.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;
    ent_t          mq[$];
    bit            m_ptr_anim;   // tie-break favours anim next
    bit            m_committed;  // commit already reported in this blank with nothing new since
    logic          m_we, m_cd, m_err;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_d;
    logic          obs_hr, obs_ar, exp_hr, exp_ar;

    function automatic void model_reset();
        mq.delete();
        m_ptr_anim  = 1'b0;
        m_committed = 1'b0;
        m_we = 1'b0; m_cd = 1'b0; m_err = 1'b0;
        m_waddr = '0; m_d = '0;
    endfunction

    function automatic logic model_host_ready();
        if (mq.size() >= 8) return 1'b0;
        if (host_valid && anim_valid) return !m_ptr_anim;
        return host_valid;
    endfunction

    function automatic logic model_anim_ready();
        if (mq.size() >= 8) return 1'b0;
        if (host_valid && anim_valid) return m_ptr_anim;
        return anim_valid;
    endfunction

    // Advance one clock: sample ready, update the model, return at the next falling edge.
    task automatic step();
        ent_t          e;
        logic          hacc, aacc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        obs_hr = host_ready;
        obs_ar = anim_ready;
        exp_hr = model_host_ready();
        exp_ar = model_anim_ready();
        hacc = host_valid && exp_hr;
        aacc = anim_valid && exp_ar;
        m_we = 1'b0; m_waddr = '0; m_d = '0; m_cd = 1'b0; m_err = 1'b0;
        if (vblank) begin
            if (mq.size() != 0) begin
                e = mq.pop_front();
                m_we = 1'b1; m_waddr = e.addr; m_d = e.data;
                m_committed = 1'b0;
            end else if (!m_committed) begin
                m_cd = 1'b1;
                m_committed = 1'b1;
            end
        end else begin
            m_committed = 1'b0;
        end
        if (hacc || aacc) begin
            a = hacc ? host_addr : anim_addr;
            d = hacc ? host_data : anim_data;
            if (a < 100) mq.push_back('{a, d});
            else m_err = 1'b1;
            m_ptr_anim = hacc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        host_valid = 1'b0; anim_valid = 1'b0; vblank = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic host_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_valid = 1'b1; host_addr = a; host_data = d;
        step();
        host_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (cbram_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %0b expected 0", cbram_we); end
        n_checks++; if (cbram_waddr !== '0) begin n_errors++; $display("FAIL reset_waddr: got %0d expected 0", cbram_waddr); end
        n_checks++; if (cbram_d !== '0) begin n_errors++; $display("FAIL reset_d: got %0h expected 0", cbram_d); end
        n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        n_checks++; if (commit_done !== 1'b0 || addr_err !== 1'b0) begin n_errors++; $display("FAIL reset_pulses: got %0b%0b expected 00", commit_done, addr_err); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_commit();
        host_push(10'd4, 8'h20);
        n_checks++; if (obs_hr !== 1'b1) begin n_errors++; $display("FAIL basic_ready0: got %0b expected 1", obs_hr); end
        host_push(10'd5, 8'h30);
        n_checks++; if (obs_hr !== 1'b1) begin n_errors++; $display("FAIL basic_ready1: got %0b expected 1", obs_hr); end
        step();
        n_checks++; if (pending !== 4'd2) begin n_errors++; $display("FAIL basic_pending: got %0d expected 2", pending); end
        n_checks++; if (cbram_we !== 1'b0) begin n_errors++; $display("FAIL basic_no_write: got %0b expected 0", cbram_we); end
        vblank = 1'b1;
        step();
        n_checks++; if ({cbram_we, cbram_waddr, cbram_d} !== {1'b1, 10'd4, 8'h20}) begin n_errors++; $display("FAIL basic_wr0: got we=%0b a=%0d d=%0h expected we=1 a=4 d=20", cbram_we, cbram_waddr, cbram_d); end
        step();
        n_checks++; if ({cbram_we, cbram_waddr, cbram_d} !== {1'b1, 10'd5, 8'h30}) begin n_errors++; $display("FAIL basic_wr1: got we=%0b a=%0d d=%0h expected we=1 a=5 d=30", cbram_we, cbram_waddr, cbram_d); end
        step();
        n_checks++; if ({commit_done, cbram_we, cbram_waddr, cbram_d} !== {1'b1, 1'b0, 10'd0, 8'h00}) begin n_errors++; $display("FAIL basic_commit: got cd=%0b we=%0b a=%0d d=%0h expected cd=1 we=0 a=0 d=0", commit_done, cbram_we, cbram_waddr, cbram_d); end
        step();
        n_checks++; if (commit_done !== 1'b0) begin n_errors++; $display("FAIL basic_commit_once: got %0b expected 0", commit_done); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int hi, ai;
        logic [AW-1:0] wr [4];
        logic [AW-1:0] exp_order [4];
        exp_order[0] = 10'd10; exp_order[1] = 10'd20; exp_order[2] = 10'd11; exp_order[3] = 10'd21;
        apply_reset();
        hi = 0; ai = 0;
        host_valid = 1'b1; anim_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_addr = AW'(10 + hi); host_data = DW'(hi);
            anim_addr = AW'(20 + ai); anim_data = DW'(8'h80 + ai);
            step();
            n_checks++; if (obs_hr !== ((i % 2) == 0) || obs_ar !== ((i % 2) == 1)) begin n_errors++; $display("FAIL rr_grant%0d: got h=%0b a=%0b expected h=%0b a=%0b", i, obs_hr, obs_ar, (i % 2) == 0, (i % 2) == 1); end
            if (exp_hr) hi++;
            if (exp_ar) ai++;
        end
        host_valid = 1'b0; anim_valid = 1'b0;
        vblank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            wr[i] = cbram_we ? cbram_waddr : '1;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (wr[i] !== exp_order[i]) begin n_errors++; $display("FAIL rr_order%0d: got %0d expected %0d", i, wr[i], exp_order[i]); end
        end
        step();
        vblank = 1'b0;
        step();
    endtask

    task automatic test_full_fifo();
        apply_reset();
        for (int i = 0; i < 8; i++) host_push(AW'(30 + i), DW'($urandom_range(0, 255)));
        n_checks++; if (pending !== 4'd8) begin n_errors++; $display("FAIL full_pending: got %0d expected 8", pending); end
        host_valid = 1'b1; host_addr = 10'd40; host_data = 8'h44;
        anim_valid = 1'b1; anim_addr = 10'd41; anim_data = 8'h55;
        step();
        n_checks++; if (obs_hr !== 1'b0 || obs_ar !== 1'b0) begin n_errors++; $display("FAIL full_ready: got h=%0b a=%0b expected 0 0", obs_hr, obs_ar); end
        vblank = 1'b1;
        step();
        n_checks++; if (obs_hr !== 1'b0 || obs_ar !== 1'b0) begin n_errors++; $display("FAIL full_prepop: got h=%0b a=%0b expected 0 0", obs_hr, obs_ar); end
        step();
        n_checks++; if (obs_ar !== 1'b1 || obs_hr !== 1'b0) begin n_errors++; $display("FAIL full_slot: got h=%0b a=%0b expected h=0 a=1", obs_hr, obs_ar); end
        anim_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 0) host_valid = 1'b0;
            n_checks++; if ({cbram_we, cbram_waddr, cbram_d, commit_done} !== {m_we, m_waddr, m_d, m_cd}) begin n_errors++; $display("FAIL full_drain%0d: got we=%0b a=%0d d=%0h cd=%0b expected we=%0b a=%0d d=%0h cd=%0b", i, cbram_we, cbram_waddr, cbram_d, commit_done, m_we, m_waddr, m_d, m_cd); end
        end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_partial_vblank();
        int writes, dones;
        apply_reset();
        for (int i = 0; i < 6; i++) host_push(AW'(50 + i), DW'($urandom_range(0, 255)));
        writes = 0; dones = 0;
        vblank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            writes += int'(cbram_we); dones += int'(commit_done);
        end
        vblank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            writes += int'(cbram_we); dones += int'(commit_done);
        end
        n_checks++; if (writes != 3) begin n_errors++; $display("FAIL partial_writes: got %0d expected 3", writes); end
        n_checks++; if (pending !== 4'd3) begin n_errors++; $display("FAIL partial_pending: got %0d expected 3", pending); end
        n_checks++; if (dones != 0) begin n_errors++; $display("FAIL partial_no_commit: got %0d expected 0", dones); end
        writes = 0; dones = 0;
        vblank = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            writes += int'(cbram_we); dones += int'(commit_done);
            n_checks++; if ({cbram_we, cbram_waddr, cbram_d} !== {m_we, m_waddr, m_d}) begin n_errors++; $display("FAIL partial_wr%0d: got we=%0b a=%0d d=%0h expected we=%0b a=%0d d=%0h", i, cbram_we, cbram_waddr, cbram_d, m_we, m_waddr, m_d); end
        end
        n_checks++; if (writes != 3 || dones != 1) begin n_errors++; $display("FAIL partial_resume: got writes=%0d dones=%0d expected 3 1", writes, dones); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_addr_err();
        int writes;
        apply_reset();
        anim_valid = 1'b1; anim_addr = 10'd100; anim_data = 8'hAA;
        step();
        anim_valid = 1'b0;
        n_checks++; if (obs_ar !== 1'b1) begin n_errors++; $display("FAIL err_ready: got %0b expected 1", obs_ar); end
        n_checks++; if (addr_err !== 1'b1) begin n_errors++; $display("FAIL err_pulse: got %0b expected 1", addr_err); end
        n_checks++; if (pending !== 4'd0) begin n_errors++; $display("FAIL err_pending: got %0d expected 0", pending); end
        step();
        n_checks++; if (addr_err !== 1'b0) begin n_errors++; $display("FAIL err_single: got %0b expected 0", addr_err); end
        host_push(10'd99, 8'h11);
        n_checks++; if (addr_err !== 1'b0 || pending !== 4'd1) begin n_errors++; $display("FAIL err_edge99: got err=%0b pending=%0d expected 0 1", addr_err, pending); end
        writes = 0;
        vblank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            writes += int'(cbram_we);
            n_checks++; if (cbram_we && cbram_waddr !== 10'd99) begin n_errors++; $display("FAIL err_bram_addr: got %0d expected 99", cbram_waddr); end
        end
        n_checks++; if (writes != 1) begin n_errors++; $display("FAIL err_writes: got %0d expected 1", writes); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_drain();
        int writes, dones;
        apply_reset();
        for (int i = 0; i < 4; i++) host_push(AW'(7 + i), DW'(8'h60 + i));
        vblank = 1'b1;
        step();
        n_checks++; if (cbram_we !== 1'b1 || cbram_waddr !== 10'd7) begin n_errors++; $display("FAIL rst_pre: got we=%0b a=%0d expected 1 7", cbram_we, cbram_waddr); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if ({cbram_we, cbram_waddr, cbram_d, commit_done, addr_err} !== '0) begin n_errors++; $display("FAIL rst_async: got we=%0b a=%0d d=%0h cd=%0b err=%0b expected all 0", cbram_we, cbram_waddr, cbram_d, commit_done, addr_err); end
        n_checks++; if (pending !== 4'd0) begin n_errors++; $display("FAIL rst_pending: got %0d expected 0", pending); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        writes = 0; dones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            writes += int'(cbram_we); dones += int'(commit_done);
        end
        n_checks++; if (writes != 0 || dones != 1) begin n_errors++; $display("FAIL rst_after: got writes=%0d dones=%0d expected 0 1", writes, dones); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            host_valid = 1'($urandom_range(0, 1));
            host_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(100, 1023)) : AW'($urandom_range(0, 99));
            host_data  = DW'($urandom_range(0, 255));
            anim_valid = 1'($urandom_range(0, 1));
            anim_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(100, 1023)) : AW'($urandom_range(0, 99));
            anim_data  = DW'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) vblank = ~vblank;
            step();
            n_checks++; if ((host_valid || anim_valid) && (obs_hr !== exp_hr || obs_ar !== exp_ar)) begin n_errors++; $display("FAIL rand_ready cyc %0d: got h=%0b a=%0b expected h=%0b a=%0b", i, obs_hr, obs_ar, exp_hr, exp_ar); end
            n_checks++; if (obs_hr === 1'b1 && obs_ar === 1'b1) begin n_errors++; $display("FAIL rand_excl cyc %0d: got both ready expected at most one", i); end
            n_checks++; if ({cbram_we, cbram_waddr, cbram_d} !== {m_we, m_waddr, m_d}) begin n_errors++; $display("FAIL rand_bram cyc %0d: got we=%0b a=%0d d=%0h expected we=%0b a=%0d d=%0h", i, cbram_we, cbram_waddr, cbram_d, m_we, m_waddr, m_d); end
            n_checks++; if (commit_done !== m_cd || addr_err !== m_err) begin n_errors++; $display("FAIL rand_pulse cyc %0d: got cd=%0b err=%0b expected cd=%0b err=%0b", i, commit_done, addr_err, m_cd, m_err); end
            n_checks++; if (pending !== CW'(mq.size())) begin n_errors++; $display("FAIL rand_pending cyc %0d: got %0d expected %0d", i, pending, mq.size()); end
        end
        host_valid = 1'b0; anim_valid = 1'b0; vblank = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_commit();
        test_round_robin();
        test_full_fifo();
        test_partial_vblank();
        test_addr_err();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
